flash_burst_reader: RTL and testbench

FLASH_BURST_READER -- requirements
Module: flash_burst_reader

---
 rtl/flash_burst_reader.sv | 149 ++++++++++++++
 tb/tb_flash_burst_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_burst_reader.sv
// Streams word_count flash words from start_addr through a prefetch FIFO,
// issuing burst reads only when the FIFO has room for the whole burst.
module flash_burst_reader #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int BURST_MAX  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_read,
  output logic [4:0]        flash_burstcount,
  input  logic              flash_waitrequest,
  input  logic [DATA_W-1:0] flash_readdata,
  input  logic              flash_readdatavalid
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  delivered;
  logic [4:0]        beats;
  logic [4:0]        burst;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;

  logic space, accept, wr, rd, last_beat, fin_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign burst = (remaining < CNT_W'(BURST_MAX)) ?
                 5'(remaining) : 5'(BURST_MAX);

  // Whole burst must fit so a returned beat never meets a full FIFO.
  assign space     = (32'(count) + 32'(burst)) <= FIFO_DEPTH;
  assign accept    = flash_read && !flash_waitrequest;
  assign wr        = (state == COLLECT) && flash_readdatavalid;
  assign rd        = out_valid && out_ready;
  assign last_beat = wr && (beats == 5'd1);
  assign fin_ok    = (count == '0) && (delivered == target);

  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (word_count == '0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        if (accept) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (last_beat)
          state_nxt = (remaining != '0) ? ISSUE : FINISH;
      end
      FINISH: begin
        if (fin_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy             = (state != IDLE);
    done             = (state == FINISH) && fin_ok;
    flash_read       = (state == ISSUE) && space;
    flash_addr       = flash_read ? cur_addr : '0;
    flash_burstcount = flash_read ? burst : 5'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      target    <= '0;
      delivered <= '0;
      beats     <= '0;
    end else begin
      if (state == IDLE && start) begin
        cur_addr  <= start_addr;
        remaining <= word_count;
        target    <= word_count;
        delivered <= '0;
      end
      if (accept) begin
        cur_addr  <= cur_addr + ADDR_W'(burst);
        remaining <= remaining - CNT_W'(burst);
        beats     <= burst;
      end
      if (wr) beats <= beats - 5'd1;
      if (rd) delivered <= delivered + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= ptr_inc(wptr);
      if (rd) rptr <= ptr_inc(rptr);
      unique case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= flash_readdata;
  end

endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed bench for flash_burst_reader: flash model with 2-cycle latency
// and a scoreboard of expected stream words.
module tb_flash_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [22:0] start_addr;
  logic [15:0] word_count;
  logic        busy, done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] flash_addr;
  logic        flash_read;
  logic [4:0]  flash_burstcount;
  logic        flash_waitrequest;
  logic [31:0] flash_readdata;
  logic        flash_readdatavalid;

  flash_burst_reader dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .start_addr          (start_addr),
    .word_count          (word_count),
    .busy                (busy),
    .done                (done),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .flash_addr          (flash_addr),
    .flash_read          (flash_read),
    .flash_burstcount    (flash_burstcount),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] addr;
    int          due;
  } beat_t;

  typedef struct {
    logic [22:0] addr;
    logic [4:0]  bc;
  } cmd_t;

  beat_t       pend[$];
  cmd_t        cmd_q[$];
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int beats_sent = 0;
  int done_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    return {8'hD5, 1'b0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flash model: beats start two cycles after the accepting edge.
  always @(negedge clk) begin
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      beat_t b;
      b = pend.pop_front();
      flash_readdatavalid = 1'b1;
      flash_readdata      = mem_word(b.addr);
      beats_sent++;
    end else begin
      flash_readdatavalid = 1'b0;
      flash_readdata      = '0;
    end
    if (flash_read === 1'b1 && flash_waitrequest === 1'b0) begin
      cmd_q.push_back('{flash_addr, flash_burstcount});
      for (int i = 0; i < int'(flash_burstcount); i++)
        pend.push_back('{flash_addr + 23'(i), cyc + 2 + i});
    end
  end

  // Output monitor and done counter.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL spurious_out observed=%0h expected=none", out_data);
      end
      if (exp_q.size() > 0)
        chk("stream_data", out_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [22:0] a, input int n);
    start      = 1'b1;
    start_addr = a;
    word_count = 16'(n);
    for (int i = 0; i < n; i++) exp_q.push_back(mem_word(a + 23'(i)));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic chk_cmd(input string tag, input int idx,
                         input logic [22:0] a, input int bc);
    if (idx < cmd_q.size()) begin
      chk({tag, "_addr"}, cmd_q[idx].addr, a);
      chk({tag, "_bc"}, cmd_q[idx].bc, 64'(bc));
    end else begin
      chk({tag, "_missing"}, cmd_q.size(), 64'(idx + 1));
    end
  endtask

  initial begin
    int d0;
    int s0;
    int k;
    reset               = 1'b1;
    start               = 1'b0;
    start_addr          = '0;
    word_count          = '0;
    out_ready           = 1'b0;
    flash_waitrequest   = 1'b0;
    flash_readdata      = '0;
    flash_readdatavalid = 1'b0;
    repeat (2) tick();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_read", flash_read, 0);
    chk("rst_addr", flash_addr, 0);
    chk("rst_bc", flash_burstcount, 0);
    reset = 1'b0;
    tick();

    // Basic 10-word transfer; a start while busy must be ignored.
    out_ready = 1'b1;
    cmd_q.delete();
    d0 = done_cnt;
    start_xfer(23'h100, 10);
    repeat (3) tick();
    start      = 1'b1;
    start_addr = 23'h900;
    word_count = 16'd5;
    tick();
    start = 1'b0;
    wait_done("t1_done", 200);
    repeat (3) tick();
    chk("t1_ncmd", cmd_q.size(), 3);
    chk_cmd("t1_c0", 0, 23'h100, 4);
    chk_cmd("t1_c1", 1, 23'h104, 4);
    chk_cmd("t1_c2", 2, 23'h108, 2);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_one_done", done_cnt - d0, 1);

    // Zero-length transfer.
    cmd_q.delete();
    d0 = done_cnt;
    chk("t2_idle", busy, 0);
    start_xfer(23'h40, 0);
    chk("t2_busy", busy, 1);
    chk("t2_done", done, 1);
    tick();
    chk("t2_busy_off", busy, 0);
    chk("t2_done_off", done, 0);
    chk("t2_ncmd", cmd_q.size(), 0);
    chk("t2_one_done", done_cnt - d0, 1);

    // Stalled consumer: FIFO fills to 8 then bursts stop.
    out_ready = 1'b0;
    cmd_q.delete();
    s0 = beats_sent;
    start_xfer(23'h2000, 20);
    repeat (40) tick();
    chk("t3_buffered", beats_sent - s0, 8);
    chk("t3_ncmd", cmd_q.size(), 2);
    chk("t3_valid", out_valid, 1);
    chk("t3_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_no_read", flash_read, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_done("t3_done", 300);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_total_cmd", cmd_q.size(), 5);
    chk_cmd("t3_c4", 4, 23'h2010, 4);

    // Waitrequest held for 5 cycles in ISSUE.
    cmd_q.delete();
    flash_waitrequest = 1'b1;
    start_xfer(23'h300, 4);
    for (int i = 0; i < 5; i++) begin
      chk("t4_read", flash_read, 1);
      chk("t4_addr", flash_addr, 23'h300);
      chk("t4_bc", flash_burstcount, 4);
      tick();
    end
    flash_waitrequest = 1'b0;
    wait_done("t4_done", 100);
    chk("t4_ncmd", cmd_q.size(), 1);
    chk_cmd("t4_c0", 0, 23'h300, 4);
    chk("t4_drained", exp_q.size(), 0);

    // Address wrap at the top of the flash.
    cmd_q.delete();
    start_xfer(23'h7FFFFE, 4);
    wait_done("t5_done", 100);
    chk_cmd("t5_c0", 0, 23'h7FFFFE, 4);
    chk("t5_drained", exp_q.size(), 0);

    // Reset in COLLECT with two beats outstanding.
    s0 = beats_sent;
    start_xfer(23'h500, 8);
    k = 0;
    while (beats_sent < s0 + 2 && k < 50) begin
      tick();
      k++;
    end
    chk("t6_two_beats", beats_sent - s0, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_read", flash_read, 0);
    chk("t6_addr", flash_addr, 0);
    chk("t6_bc", flash_burstcount, 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_late_valid", out_valid, 0);
      chk("t6_late_busy", busy, 0);
    end
    chk("t6_late_beats", beats_sent - s0, 4);
    cmd_q.delete();
    start_xfer(23'h600, 6);
    wait_done("t6_done", 150);
    chk("t6_ncmd", cmd_q.size(), 2);
    chk_cmd("t6_c0", 0, 23'h600, 4);
    chk_cmd("t6_c1", 1, 23'h604, 2);
    chk("t6_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
